seq_dot_engine: RTL and testbench

Digit-serial, precision-scalable K-element signed/unsigned dot-product MAC computing d = acc0 + sum_k row[k]*column[k].
- Row operands are consumed P bits per cycle against the full-width column operands, so latency scales with the requested precision.
- acc0 is either c_in_i or the previous result, which allows long dot products to be chained.
- Sits as the processing element inside the PE array, behind a valid/ready handshake on both sides.

---
 rtl/seq_dot_pkg.sv | 39 +++
 rtl/seq_dot_digit_mac.sv | 38 +++
 rtl/seq_dot_engine.sv | 151 +++++++++++++++
 tb/tb_seq_dot_engine.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/seq_dot_pkg.sv
// seq_dot_engine shared types, width helpers and the saturation clamp.
// Build option: SEQ_DOT_SAT_EN selects saturating output (see seq_dot_engine).
package seq_dot_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_t;

  localparam int CW = 128;

  function automatic int calc_iw(input int acc_w, input int max_w, input int k);
    int prod_w;
    prod_w = 2 * max_w + $clog2(k);
    return ((acc_w > prod_w) ? acc_w : prod_w) + 2;
  endfunction

  function automatic int calc_bs_w(input int ndig);
    return $clog2(ndig) + 1;
  endfunction

  function automatic logic signed [CW-1:0] sat_max(input int w);
    logic signed [CW-1:0] one;
    one = {{(CW-1){1'b0}}, 1'b1};
    return (one <<< (w - 1)) - one;
  endfunction

  function automatic logic sat_hit(input logic signed [CW-1:0] v, input int w);
    return (v > sat_max(w)) || (v < ~sat_max(w));
  endfunction

  function automatic logic signed [CW-1:0] clamp(input logic signed [CW-1:0] v, input int w);
    if (v > sat_max(w)) return sat_max(w);
    if (v < ~sat_max(w)) return ~sat_max(w);
    return v;
  endfunction

endpackage

// File: rtl/seq_dot_digit_mac.sv
// One digit step of the dot product: K products of a P-bit row digit
// against the extended column element, summed into a signed partial sum.
module seq_dot_digit_mac
  import seq_dot_pkg::*;
#(
  parameter int K = 4,
  parameter int P = 2,
  parameter int MAX_WIDTH = 16,
  parameter int SW = 4,
  parameter int PW = P + MAX_WIDTH + 3 + $clog2(K)
) (
  input  logic [SW-1:0]               sel,
  input  logic                        top_signed,
  input  logic [K-1:0][MAX_WIDTH-1:0] row,
  input  logic [K-1:0][MAX_WIDTH:0]   col,
  output logic signed [PW-1:0]        psum
);

  localparam int PRW = P + MAX_WIDTH + 2;

  logic signed [P:0]     dig [K];
  logic signed [PRW-1:0] dx  [K];
  logic signed [PRW-1:0] cx  [K];
  logic signed [PRW-1:0] prod[K];

  // Top digit of a signed row carries negative weight; all others are unsigned.
  always_comb begin
    psum = '0;
    for (int k = 0; k < K; k++) begin
      dig[k]  = {top_signed & row[k][sel*P+P-1], row[k][sel*P+:P]};
      dx[k]   = {{(MAX_WIDTH+1){dig[k][P]}}, dig[k]};
      cx[k]   = {{(P+1){col[k][MAX_WIDTH]}}, col[k]};
      prod[k] = dx[k] * cx[k];
      psum    = psum + {{(PW-PRW){prod[k][PRW-1]}}, prod[k]};
    end
  end

endmodule

// File: rtl/seq_dot_engine.sv
// Digit-serial precision-scalable K-element dot-product MAC with handshakes.
// Build option: define SEQ_DOT_SAT_EN for saturating output and sticky overflow_o.
module seq_dot_engine
  import seq_dot_pkg::*;
#(
  parameter int K = 4,
  parameter int P = 2,
  parameter int MAX_WIDTH = 16,
  parameter int ACC_WIDTH = 40
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [K-1:0][MAX_WIDTH-1:0]   row_i,
  input  logic [K-1:0][MAX_WIDTH-1:0]   column_i,
  input  logic signed [ACC_WIDTH-1:0]   c_in_i,
  input  logic [$clog2(MAX_WIDTH/P):0]  bit_size_i,
  input  logic                          signed_a_i,
  input  logic                          signed_b_i,
  input  logic                          accum_i,
  input  logic                          valid_in_i,
  output logic                          ready_in_o,
  output logic signed [ACC_WIDTH-1:0]   d_o,
  output logic                          valid_out_o,
  input  logic                          ready_out_i,
  output logic                          overflow_o
);

  localparam int NDIG = MAX_WIDTH / P;
  localparam int BS_W = calc_bs_w(NDIG);
  localparam int IW   = calc_iw(ACC_WIDTH, MAX_WIDTH, K);
  localparam int PW   = P + MAX_WIDTH + 3 + $clog2(K);

  state_t state, state_nxt;

  logic [BS_W-1:0]              n_in, n_q, cnt;
  logic [K-1:0][MAX_WIDTH-1:0]  row_q;
  logic [K-1:0][MAX_WIDTH:0]    col_ext, col_q;
  logic                         sa_q;
  logic signed [IW-1:0]         acc, acc_nxt;
  logic signed [PW-1:0]         psum;
  logic signed [ACC_WIDTH-1:0]  res;
  logic                         last, accept;
  int                           wbits;

  assign accept = valid_in_i & ready_in_o;
  assign last   = (cnt == n_q - BS_W'(1));

  // Precision: 0 and oversize requests mean full width.
  always_comb begin
    n_in = bit_size_i;
    if (bit_size_i == '0 || bit_size_i > BS_W'(NDIG)) n_in = BS_W'(NDIG);
  end

  // Mask column elements to the active width and extend to MAX_WIDTH+1 bits.
  always_comb begin
    wbits   = int'(n_in) * P;
    col_ext = '0;
    for (int k = 0; k < K; k++) begin
      col_ext[k][MAX_WIDTH] = signed_b_i & column_i[k][wbits-1];
      for (int b = 0; b < MAX_WIDTH; b++) begin
        col_ext[k][b] = (b < wbits) ? column_i[k][b] : col_ext[k][MAX_WIDTH];
      end
    end
  end

  seq_dot_digit_mac #(
    .K(K),
    .P(P),
    .MAX_WIDTH(MAX_WIDTH),
    .SW(BS_W),
    .PW(PW)
  ) u_mac (
    .sel(cnt),
    .top_signed(sa_q & last),
    .row(row_q),
    .col(col_q),
    .psum(psum)
  );

  // Weight the digit partial sum by its position and accumulate.
  always_comb begin
    acc_nxt = acc + ($signed({{(IW-PW){psum[PW-1]}}, psum}) <<< (int'(cnt) * P));
  end

`ifdef SEQ_DOT_SAT_EN
  logic signed [CW-1:0] wide;
  logic                 ovf;

  assign wide = {{(CW-IW){acc_nxt[IW-1]}}, acc_nxt};
  assign ovf  = sat_hit(wide, ACC_WIDTH);
  assign res  = ACC_WIDTH'(clamp(wide, ACC_WIDTH));

  // Sticky saturation flag, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) overflow_o <= 1'b0;
    else if (state == COMPUTE && last && ovf) overflow_o <= 1'b1;
  end
`else
  assign res        = acc_nxt[ACC_WIDTH-1:0];
  assign overflow_o = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (valid_in_i) state_nxt = COMPUTE;
      COMPUTE: if (last) state_nxt = DONE;
      DONE:    if (ready_out_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    ready_in_o  = (state == IDLE);
    valid_out_o = (state == DONE);
  end

  // Operand capture, digit stepping and result register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_o   <= '0;
      cnt   <= '0;
      n_q   <= '0;
      acc   <= '0;
      row_q <= '0;
      col_q <= '0;
      sa_q  <= 1'b0;
    end else if (accept) begin
      row_q <= row_i;
      col_q <= col_ext;
      n_q   <= n_in;
      sa_q  <= signed_a_i;
      cnt   <= '0;
      acc   <= accum_i ? {{(IW-ACC_WIDTH){d_o[ACC_WIDTH-1]}}, d_o}
                       : {{(IW-ACC_WIDTH){c_in_i[ACC_WIDTH-1]}}, c_in_i};
    end else if (state == COMPUTE) begin
      acc <= acc_nxt;
      cnt <= cnt + BS_W'(1);
      if (last) d_o <= res;
    end
  end

endmodule

// File: tb/tb_seq_dot_engine.sv
// Directed vector bench for seq_dot_engine (ACC_WIDTH 40 and 32 instances).
// Expected 32-bit results follow SEQ_DOT_SAT_EN.
module tb_seq_dot_engine;

  localparam int K  = 4;
  localparam int P  = 2;
  localparam int MW = 16;
  localparam int AW = 40;
`ifdef SEQ_DOT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [K-1:0][MW-1:0]   row, col;
  logic signed [AW-1:0]   c_in;
  logic [3:0]             bs;
  logic                   sa, sb, accum, vin, rout;
  logic                   rin, vout, ovf;
  logic                   rin32, vout32, ovf32;
  logic signed [AW-1:0]   d;
  logic signed [31:0]     d32;
  int                     n_cmp = 0;
  int                     n_bad = 0;

  always #5 clk = ~clk;

  seq_dot_engine #(.K(K), .P(P), .MAX_WIDTH(MW), .ACC_WIDTH(AW)) u_dut (
    .clk_i(clk), .rst_i(rst), .row_i(row), .column_i(col), .c_in_i(c_in),
    .bit_size_i(bs), .signed_a_i(sa), .signed_b_i(sb), .accum_i(accum),
    .valid_in_i(vin), .ready_in_o(rin), .d_o(d), .valid_out_o(vout),
    .ready_out_i(rout), .overflow_o(ovf)
  );

  seq_dot_engine #(.K(K), .P(P), .MAX_WIDTH(MW), .ACC_WIDTH(32)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .row_i(row), .column_i(col), .c_in_i(c_in[31:0]),
    .bit_size_i(bs), .signed_a_i(sa), .signed_b_i(sb), .accum_i(accum),
    .valid_in_i(vin), .ready_in_o(rin32), .d_o(d32), .valid_out_o(vout32),
    .ready_out_i(rout), .overflow_o(ovf32)
  );

  typedef struct {
    string                nm;
    logic [3:0]           bs;
    logic                 sa, sb, acc;
    logic [K-1:0][MW-1:0] row, col;
    longint               cin, exp, exp32;
    logic                 ov32;
  } vec_t;

  vec_t tv[9];

  function automatic vec_t mk(input string nm, input int b, input bit a, input bit s,
                              input bit ac, input logic [63:0] r, input logic [63:0] c,
                              input longint ci, input longint e, input longint e32,
                              input bit o);
    vec_t v;
    v.nm = nm; v.bs = b[3:0]; v.sa = a; v.sb = s; v.acc = ac;
    v.row = r; v.col = c; v.cin = ci; v.exp = e; v.exp32 = e32; v.ov32 = o;
    return v;
  endfunction

  task automatic chk(input string nm, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    row = v.row; col = v.col; bs = v.bs; sa = v.sa; sb = v.sb;
    accum = v.acc; c_in = v.cin[AW-1:0];
  endtask

  task automatic run(input vec_t v);
    int lat;
    int n;
    n = (v.bs == 0 || v.bs > 8) ? 8 : int'(v.bs);
    @(negedge clk);
    chk({v.nm, ".rdy"}, rin, 1);
    drive(v);
    vin = 1'b1;
    @(posedge clk); #1;
    vin = 1'b0;
    lat = 1;
    while (!vout && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({v.nm, ".lat"}, lat, n + 1);
    chk({v.nm, ".d"}, d, v.exp);
    chk({v.nm, ".d32"}, d32, v.exp32);
    chk({v.nm, ".ovf32"}, ovf32, v.ov32);
    chk({v.nm, ".ovf"}, ovf, 0);
    @(posedge clk); #1;
    chk({v.nm, ".idle"}, {rin, vout}, 2'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hi;
    vec_t v;

    tv[0] = mk("s2", 1, 1, 1, 0, 64'h0000_0000_0001_FFFE, 64'h0000_0000_FFFE_0001,
               5, 1, 1, 0);
    tv[1] = mk("s16", 8, 1, 1, 0, {4{16'h7FFF}}, {4{16'h7FFF}},
               0, 64'd4294705156, SAT ? 2147483647 : -262140, SAT);
    tv[2] = mk("u8", 4, 0, 0, 0, 64'h00FF, 64'h00FF, 0, 65025, 65025, SAT);
    tv[3] = mk("s8", 4, 1, 1, 0, 64'h00FF, 64'h00FF, 0, 1, 1, SAT);
    tv[4] = mk("bs0", 0, 0, 0, 0, 64'hFFFF, 64'hFFFF,
               0, 64'd4294836225, SAT ? 2147483647 : -131071, SAT);
    tv[5] = mk("bs1u", 1, 0, 0, 0, 64'hFFF3, 64'h0005, -10, -7, -7, SAT);
    tv[6] = mk("bsbig", 15, 1, 1, 0, 64'h8000, 64'h8000,
               0, 1073741824, 1073741824, SAT);
    tv[7] = mk("chain1", 8, 1, 1, 0, 64'd3, 64'd4, 0, 12, 12, SAT);
    tv[8] = mk("chain2", 8, 1, 1, 1, 64'd5, 64'd6, 999, 42, 42, SAT);

    rst = 1'b1; vin = 1'b0; rout = 1'b1;
    row = '0; col = '0; c_in = '0; bs = '0; sa = 1'b0; sb = 1'b0; accum = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.d", d, 0);
    chk("rst.vout", vout, 0);
    chk("rst.rin", rin, 1);
    chk("rst.ovf32", ovf32, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run(tv[i]);

    // Backpressure: result held while consumer stalls, new requests ignored.
    rout = 1'b0;
    @(negedge clk);
    drive(tv[3]);
    vin = 1'b1;
    @(posedge clk); #1;
    vin = 1'b0;
    hi = 0;
    while (!vout && hi < 40) begin
      @(posedge clk); #1;
      hi++;
    end
    chk("bp.lat", hi, 4);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(tv[1]);
      vin = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("bp.hold%0d", c), {vout, rin, d}, {1'b1, 1'b0, 40'sd1});
    end
    @(negedge clk);
    vin = 1'b0;
    rout = 1'b1;
    @(posedge clk); #1;
    chk("bp.release", {rin, vout, d}, {1'b1, 1'b0, 40'sd1});

    // Reset mid-compute discards the transaction.
    @(negedge clk);
    drive(tv[1]);
    vin = 1'b1;
    @(posedge clk); #1;
    vin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst.state", {rin, vout, d}, {1'b1, 1'b0, 40'sd0});
    chk("mrst.ovf32", ovf32, 0);
    @(negedge clk);
    rst = 1'b0;
    hi = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (vout) hi++;
    end
    chk("mrst.noout", hi, 0);

    // Chaining after reset starts from a zero accumulator.
    v = mk("postrst", 8, 1, 1, 1, 64'd2, 64'd3, 777, 6, 6, 0);
    run(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
